// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, default width, counter sizing.
// Used by the digit-serial add path, serial_adder_16.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  // Digit counter width; a single-digit operation still needs a 1-bit counter.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; chained DIGIT-wide to form the per-cycle ripple stage.
// Purely combinational, no backpressure.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_16.sv
// Digit-serial A+B+Cin, DIGIT bits per clock; oDone WIDTH/DIGIT cycles after accept, iStart ignored while busy.
// Optional signed-overflow output oOvf when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_16
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oSum,
  output logic             oCarry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             oOvf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder_16: DIGIT must divide WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] d;
  logic             last_digit;

  assign c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    full_adder u_fa (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (c[i]),
      .s  (d[i]),
      .co (c[i+1])
    );
  end

  assign last_digit = (cnt_q == CW'(N - 1));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oSum    <= '0;
      oCarry  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      oOvf    <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            a_q     <= iA;
            b_q     <= iB;
            carry_q <= iC;
            cnt_q   <= '0;
            oBusy   <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          // New digit enters at the top so the LSB digit ends up at bit 0.
          sum_q   <= WIDTH'({d, sum_q} >> DIGIT);
          carry_q <= c[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (last_digit) begin
            oSum   <= WIDTH'({d, sum_q} >> DIGIT);
            oCarry <= c[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            oOvf   <= c[DIGIT] ^ c[DIGIT-1];
`endif
            oDone  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_16.sv
// Scoreboard bench: DIGIT=1, 4 and 16 instances share stimulus; expectations come from plain integer addition.
module tb_serial_adder_16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a_in, b_in;
  logic        c_in;
  logic        start_all, start_main;
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        carry_w [3];
  logic [15:0] sum_w   [3];
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf_w   [3];
`endif

  serial_adder_16 #(.WIDTH(16), .DIGIT(1)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start_all | start_main),
    .iA(a_in), .iB(b_in), .iC(c_in),
    .oBusy(busy_w[0]), .oDone(done_w[0]), .oSum(sum_w[0]), .oCarry(carry_w[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .oOvf(ovf_w[0])
`endif
  );

  serial_adder_16 #(.WIDTH(16), .DIGIT(4)) dut4 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start_all),
    .iA(a_in), .iB(b_in), .iC(c_in),
    .oBusy(busy_w[1]), .oDone(done_w[1]), .oSum(sum_w[1]), .oCarry(carry_w[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .oOvf(ovf_w[1])
`endif
  );

  serial_adder_16 #(.WIDTH(16), .DIGIT(16)) dut16 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start_all),
    .iA(a_in), .iB(b_in), .iC(c_in),
    .oBusy(busy_w[2]), .oDone(done_w[2]), .oSum(sum_w[2]), .oCarry(carry_w[2])
`ifdef SERIAL_ADDER_OVF_EN
    , .oOvf(ovf_w[2])
`endif
  );

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    int          start_cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_of(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every oDone pops that instance's queue; between completions oSum must hold.
  logic [15:0] last_sum [3] = '{16'h0, 16'h0, 16'h0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin : mon
      exp_t e;
      bit   got;
      got = 1'b0;
      if (!rst_n) begin
        last_sum[k] = 16'h0;
      end else if (done_w[k]) begin
        case (k)
          0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done[%0d]: got oDone=1, expected no pending result", k);
        end else begin
          chk($sformatf("sum[%0d]", k), {16'h0, sum_w[k]}, {16'h0, e.sum});
          chk($sformatf("carry[%0d]", k), {31'h0, carry_w[k]}, {31'h0, e.carry});
`ifdef SERIAL_ADDER_OVF_EN
          chk($sformatf("ovf[%0d]", k), {31'h0, ovf_w[k]}, {31'h0, e.ovf});
`endif
          chk($sformatf("latency[%0d]", k), cyc - e.start_cyc - 1, n_of(k));
        end
        last_sum[k] = sum_w[k];
      end else begin
        chk($sformatf("sum_hold[%0d]", k), {16'h0, sum_w[k]}, {16'h0, last_sum[k]});
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_w[0] | busy_w[1] | busy_w[2]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 1, 0);
  endtask

  // Drives one accepted operation and queues its expected result for all instances.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t        e;
    logic [16:0] full;
    wait_idle();
    full        = {1'b0, a} + {1'b0, b} + {16'h0, c};
    e.sum       = full[15:0];
    e.carry     = full[16];
    e.ovf       = (a[15] == b[15]) && (full[15] != a[15]);
    e.start_cyc = cyc;
    q0.push_back(e);
    q1.push_back(e);
    q2.push_back(e);
    a_in      = a;
    b_in      = b;
    c_in      = c;
    start_all = 1'b1;
    @(negedge clk);
    start_all = 1'b0;
    a_in      = 16'($urandom);
    b_in      = 16'($urandom);
    c_in      = 1'($urandom);
  endtask

  logic [15:0] dir_a [9] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'hABCD, 16'h7FFF, 16'h8000, 16'h0003, 16'h0000, 16'h8000};
  logic [15:0] dir_b [9] = '{16'h4321, 16'h0001, 16'hFFFF, 16'h1111, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
  logic        dir_c [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int cnt;
    rst_n      = 1'b0;
    start_all  = 1'b0;
    start_main = 1'b0;
    a_in       = 16'h0;
    b_in       = 16'h0;
    c_in       = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy[%0d]", k), {31'h0, busy_w[k]}, 0);
      chk($sformatf("rst_done[%0d]", k), {31'h0, done_w[k]}, 0);
      chk($sformatf("rst_sum[%0d]", k), {16'h0, sum_w[k]}, 0);
      chk($sformatf("rst_carry[%0d]", k), {31'h0, carry_w[k]}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // First operation: DIGIT=1 instance stays busy for N+1 cycles.
    issue(16'h1234, 16'h4321, 1'b0);
    cnt = 0;
    while (busy_w[0] && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, 17);

    for (int i = 1; i < 9; i++) issue(dir_a[i], dir_b[i], dir_c[i]);

    // Starts during RUN and during DONE must be ignored by the DIGIT=1 instance.
    issue(16'h0001, 16'h0001, 1'b0);
    repeat (3) @(negedge clk);
    a_in       = 16'h00FF;
    b_in       = 16'h00FF;
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    cnt = 0;
    while (!done_w[0] && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("busy_test_done_seen", {31'h0, done_w[0]}, 1);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    chk("ignored_start_busy", {31'h0, busy_w[0]}, 0);
    @(negedge clk);
    chk("ignored_start_busy2", {31'h0, busy_w[0]}, 0);

    // Mid-operation reset aborts with outputs cleared at once.
    issue(16'h1111, 16'h2222, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_busy[%0d]", k), {31'h0, busy_w[k]}, 0);
      chk($sformatf("abort_sum[%0d]", k), {16'h0, sum_w[k]}, 0);
      chk($sformatf("abort_carry[%0d]", k), {31'h0, carry_w[k]}, 0);
    end
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h1111, 16'h2222, 1'b0);

    for (int i = 0; i < 30; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(16'($urandom), 16'($urandom), 1'($urandom));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("pending_q0", q0.size(), 0);
    chk("pending_q1", q1.size(), 0);
    chk("pending_q2", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder_16.md
Name: serial_adder_16

Overview:
Multi-cycle digit-serial adder; the additive counterpart of the team's 16-bit ripple subtracter datapath.
- Computes iA + iB + iC LSB-first, DIGIT bits per clock, through a small ripple chain of 1-bit full adders plus a carry flop.
- Sits in the ALU as the area-reduced add path, using a start/done handshake toward the ALU sequencer.

Parameters:
- WIDTH, 16: operand and result width in bits.
- DIGIT, 1: bits added per clock. Legal values are divisors of WIDTH (1, 2, 4, 8, 16); any other value is a static elaboration error.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iStart  input  1  request pulse; operands are sampled when accepted.
- iA  input  WIDTH  addend A.
- iB  input  WIDTH  addend B.
- iC  input  1  carry-in.
- oBusy  output  1  high while an operation is in flight (RUN or DONE).
- oDone  output  1  one-cycle pulse; oSum and oCarry are valid from this cycle.
- oSum  output  WIDTH  sum; holds its value until the next completion.
- oCarry  output  1  carry-out of the MSB.

Behaviour:
- Reset (iRst_n low, asynchronous): state IDLE; oBusy, oDone, oSum and oCarry are 0; internal shift registers, carry flop and digit counter are 0.
- States:
  - IDLE: iStart high at an edge loads iA, iB and iC into the A/B shift registers and carry flop, clears the counter and moves to RUN.
  - RUN: each edge adds the low DIGIT bits of A, B and the carry flop; shifts A/B right by DIGIT; shifts the result digit into the top of the sum shift register; updates the carry flop; increments the counter. At the edge processing digit WIDTH/DIGIT-1, it copies the sum register to oSum and the final carry to oCarry, and moves to DONE.
  - DONE: oDone=1 for exactly this one cycle; the next edge returns to IDLE.
- Latency: iStart sampled at edge 0 puts oDone high after edge N, where N = WIDTH/DIGIT. Defaults give N=16. Throughput is one operation per N+2 cycles.
- iStart while oBusy=1 (RUN or DONE) is ignored. It is neither queued nor allowed to disturb the in-flight operation.
- iA, iB and iC may change freely after acceptance; only values sampled at acceptance matter.
- oSum and oCarry change only at the completion edge and stay stable otherwise, including through IDLE.
- Arithmetic is unsigned modulo 2^WIDTH; oCarry is bit WIDTH of the full sum.
- Reset mid-operation aborts immediately: no oDone pulse, and oSum and oCarry are cleared.
- DIGIT=WIDTH is legal: RUN lasts one cycle and latency is N=1.

Optional Feature:
SERIAL_ADDER_OVF_EN
- Defined: adds output oOvf (1 bit), the two's-complement signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB. It is registered alongside oCarry, follows the same update and reset rules, and resets to 0.
- Undefined: no oOvf port and no extra logic.

Decomposition:
- Shared package alu_pkg:
  - state enum {IDLE, RUN, DONE};
  - default WIDTH=16 constant;
  - helper function computing counter width as clog2(WIDTH/DIGIT) with a minimum of 1.
- Sub-module full_adder: 1-bit sum/carry cell. It is instantiated DIGIT times in a generate loop as the per-cycle ripple chain, mirroring the team's full-subtracter structure.

Test Plan:
- WIDTH=16, DIGIT=1: iA=0x1234, iB=0x4321, iC=0 -> oSum=0x5555, oCarry=0; oDone exactly 16 cycles after the start edge; oBusy high for 17 cycles.
- iA=0xFFFF, iB=0x0001, iC=0 -> oSum=0x0000, oCarry=1. Then iA=0xFFFF, iB=0xFFFF, iC=1 -> oSum=0xFFFF, oCarry=1.
- Start 0x0001+0x0001; pulse iStart with 0x00FF+0x00FF at cycle 5 and again in the DONE cycle -> only oSum=0x0002 is produced; exactly one oDone; state returns to IDLE.
- Start 0x1111+0x2222; drop iRst_n at cycle 7 for 2 cycles -> oBusy, oSum and oCarry are 0 immediately with no oDone. A fresh start of 0x1111+0x2222 then gives oSum=0x3333 after 16 cycles.
- DIGIT=4: iA=0xABCD, iB=0x1111, iC=1 -> oSum=0xBCDF, oCarry=0, oDone 4 cycles after the start edge. DIGIT=16 gives the same result after 1 cycle.
- With SERIAL_ADDER_OVF_EN: 0x7FFF+0x0001 -> oSum=0x8000, oOvf=1, oCarry=0. Then 0x8000+0x8000 -> oSum=0x0000, oOvf=1, oCarry=1. Then 0x0003+0xFFFF -> oOvf=0.
